// File: rtl/mau_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Operation encodings, FSM states, access sizes and lane widths.
package mau_pkg;

   localparam int unsigned ByteW  = 8;
   localparam int unsigned HalfW  = 16;
   localparam int unsigned WordW  = 32;
   localparam int unsigned DwordW = 64;

   typedef enum logic [2:0] {
      OpLb  = 3'd0,
      OpLbu = 3'd1,
      OpLh  = 3'd2,
      OpLhu = 3'd3,
      OpLw  = 3'd4,
      OpSb  = 3'd5,
      OpSh  = 3'd6,
      OpSw  = 3'd7
   } mau_op_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRd   = 2'd1,
      StWr   = 2'd2,
      StResp = 2'd3
   } mau_state_t;

   typedef enum logic [1:0] {
      SzByte = 2'd0,
      SzHalf = 2'd1,
      SzWord = 2'd2
   } mau_size_t;

   function automatic logic op_is_store(input mau_op_t op);
      return (op == OpSb) || (op == OpSh) || (op == OpSw);
   endfunction

   function automatic logic op_is_signed(input mau_op_t op);
      return (op == OpLb) || (op == OpLh);
   endfunction

   function automatic mau_size_t op_size(input mau_op_t op);
      mau_size_t sz;
      case (op)
         OpLb, OpLbu, OpSb: sz = SzByte;
         OpLh, OpLhu, OpSh: sz = SzHalf;
         default:           sz = SzWord;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Combinational lane logic: merges store data into a doubleword and
// extracts/extends load data from it, little-endian lanes.
module mau_lane_merge
   import mau_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DwordW-1:0] old_dw,
   input  logic [DATA_W-1:0] data,
   input  mau_size_t         size,
   input  logic [2:0]        lane,
   input  logic              sign_ext,
   output logic [DwordW-1:0] new_dw,
   output logic [DATA_W-1:0] load_data
);

   logic [5:0]        shift;
   logic [DATA_W-1:0] mask;
   logic [ByteW-1:0]  byte_sel;
   logic [HalfW-1:0]  half_sel;
   logic [WordW-1:0]  word_sel;

   assign shift    = {lane, 3'b000};
   assign byte_sel = old_dw[shift +: ByteW];
   assign half_sel = old_dw[shift +: HalfW];
   assign word_sel = old_dw[shift +: WordW];

   always_comb begin
      mask      = '0;
      load_data = '0;
      unique case (size)
         SzByte: begin
            mask[ByteW-1:0] = '1;
            load_data = {{(DATA_W-ByteW){sign_ext & byte_sel[ByteW-1]}}, byte_sel};
         end
         SzHalf: begin
            mask[HalfW-1:0] = '1;
            load_data = {{(DATA_W-HalfW){sign_ext & half_sel[HalfW-1]}}, half_sel};
         end
         SzWord: begin
            mask      = '1;
            load_data = word_sel;
         end
         default: ;
      endcase
   end

   // Clear the selected lanes of the old doubleword, then OR in the shifted data.
   assign new_dw = (old_dw & ~({{(DwordW-DATA_W){1'b0}}, mask} << shift))
                 | ({{(DwordW-DATA_W){1'b0}}, data & mask} << shift);

endmodule

// File: rtl/mem_access_unit.sv
// MIPS32 MEM-stage load/store unit onto a 64-bit memory port (read-modify-write stores).
// Optional MAU_MISALIGN_TRAP_EN: misaligned halfword/word requests return an error without access.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  mau_op_t           req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [DwordW-1:0] mem_addr,
   output logic              mem_we,
   output logic [DwordW-1:0] mem_wdata,
   input  logic [DwordW-1:0] mem_rdata,
   input  logic              mem_err
);

   mau_state_t        state_q;
   logic              store_q;
   logic              sign_q;
   mau_size_t         size_q;
   logic [2:0]        lane_q;
   logic [DATA_W-1:0] wdata_q;

   logic              req_ready_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] resp_rdata_q;
   logic              resp_err_q;
   logic [DwordW-1:0] mem_addr_q;
   logic              mem_we_q;
   logic [DwordW-1:0] mem_wdata_q;

   mau_size_t         req_size;
   logic [ADDR_W-1:0] req_addr_al;
   logic              trap;
   logic [DwordW-1:0] merged_dw;
   logic [DATA_W-1:0] load_data;

   assign req_size = op_size(req_op);

   always_comb begin
      req_addr_al = req_addr;
      if (req_size == SzHalf) req_addr_al[0] = 1'b0;
      if (req_size == SzWord) req_addr_al[1:0] = 2'b00;
   end

`ifdef MAU_MISALIGN_TRAP_EN
   assign trap = ((req_size == SzHalf) && req_addr[0]) ||
                 ((req_size == SzWord) && (req_addr[1:0] != 2'b00));
`else
   assign trap = 1'b0;
`endif

   mau_lane_merge #(
      .DATA_W (DATA_W)
   ) u_lane_merge (
      .old_dw    (mem_rdata),
      .data      (wdata_q),
      .size      (size_q),
      .lane      (lane_q),
      .sign_ext  (sign_q),
      .new_dw    (merged_dw),
      .load_data (load_data)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         store_q      <= 1'b0;
         sign_q       <= 1'b0;
         size_q       <= SzByte;
         lane_q       <= '0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  store_q     <= op_is_store(req_op);
                  sign_q      <= op_is_signed(req_op);
                  size_q      <= req_size;
                  lane_q      <= req_addr_al[2:0];
                  wdata_q     <= req_wdata;
                  req_ready_q <= 1'b0;
                  if (trap) begin
                     state_q      <= StResp;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end else begin
                     state_q    <= StRd;
                     mem_addr_q <= {{(DwordW-ADDR_W){1'b0}}, req_addr_al[ADDR_W-1:3], 3'b000};
                  end
               end
            end
            StRd: begin
               if (!store_q) begin
                  state_q      <= StResp;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= load_data;
                  resp_err_q   <= mem_err;
                  mem_addr_q   <= '0;
               end else if (mem_err) begin
                  // Failed read: the merge base is unknown, so the write is dropped.
                  state_q      <= StResp;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= '0;
                  resp_err_q   <= 1'b1;
                  mem_addr_q   <= '0;
               end else begin
                  state_q     <= StWr;
                  mem_we_q    <= 1'b1;
                  mem_wdata_q <= merged_dw;
               end
            end
            StWr: begin
               state_q      <= StResp;
               mem_we_q     <= 1'b0;
               mem_wdata_q  <= '0;
               mem_addr_q   <= '0;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= '0;
               resp_err_q   <= 1'b0;
            end
            StResp: begin
               if (resp_ready) begin
                  state_q      <= StIdle;
                  resp_valid_q <= 1'b0;
                  resp_rdata_q <= '0;
                  resp_err_q   <= 1'b0;
                  req_ready_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Outputs are forced low while reset is held so an in-flight write cannot commit.
   assign req_ready  = req_ready_q & reset;
   assign resp_valid = resp_valid_q & reset;
   assign resp_rdata = resp_rdata_q & {DATA_W{reset}};
   assign resp_err   = resp_err_q & reset;
   assign mem_addr   = mem_addr_q & {DwordW{reset}};
   assign mem_we     = mem_we_q & reset;
   assign mem_wdata  = mem_wdata_q & {DwordW{reset}};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small doubleword memory model.
// Honours MAU_MISALIGN_TRAP_EN when choosing the misaligned-load expectation.
module tb_mem_access_unit;
   import mau_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   mau_op_t     req_op = OpLw;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [63:0] mem_addr;
   logic        mem_we;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_err;

   logic        err_inj = 1'b0;
   logic        load_init = 1'b1;
   logic [63:0] mem [0:7];
   int          n_vec = 0;
   int          n_miss = 0;

   always #5 clk = ~clk;

   mem_access_unit u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_err    (mem_err)
   );

   assign mem_rdata = mem[mem_addr[5:3]];
   assign mem_err   = err_inj;

   always @(posedge clk) begin
      if (load_init) begin
         for (int i = 0; i < 8; i++) mem[i] <= 64'h0;
         mem[0] <= 64'h8877665544332211;
      end else if (mem_we) begin
         mem[mem_addr[5:3]] <= mem_wdata;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issues one request, returns the response cycle (-1 on timeout) and observed write activity.
   task automatic run_op(input mau_op_t op, input logic [31:0] a, input logic [31:0] wd,
                         output int cyc, output logic [31:0] rd, output logic er,
                         output int we_cnt, output logic [63:0] wd_seen);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = a;
      req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      we_cnt  = 0;
      wd_seen = '0;
      @(negedge clk);
      cyc = 1;
      while (!resp_valid && cyc < 20) begin
         if (mem_we) begin
            we_cnt++;
            wd_seen = mem_wdata;
         end
         @(negedge clk);
         cyc++;
      end
      if (!resp_valid) cyc = -1;
      rd = resp_rdata;
      er = resp_err;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          cyc;
      int          we_cnt;
      logic [31:0] rd;
      logic        er;
      logic [63:0] wd_seen;
      logic [63:0] model;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_req_ready", 64'(req_ready), 64'd0);
      check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
      check_eq("rst_mem_we", 64'(mem_we), 64'd0);
      load_init = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check_eq("idle_req_ready", 64'(req_ready), 64'd1);
      check_eq("idle_resp_valid", 64'(resp_valid), 64'd0);
      check_eq("idle_mem_addr", mem_addr, 64'd0);
      model = 64'h8877665544332211;

      run_op(OpLb, 32'h1007, 32'h0, cyc, rd, er, we_cnt, wd_seen);
      check_eq("lb_data", 64'(rd), 64'hFFFFFF88);
      check_eq("lb_cycle", 64'(cyc), 64'd2);
      check_eq("lb_err", 64'(er), 64'd0);
      run_op(OpLbu, 32'h1007, 32'h0, cyc, rd, er, we_cnt, wd_seen);
      check_eq("lbu_data", 64'(rd), 64'h00000088);
      run_op(OpLhu, 32'h1002, 32'h0, cyc, rd, er, we_cnt, wd_seen);
      check_eq("lhu_data", 64'(rd), 64'h00004433);
      run_op(OpLh, 32'h1006, 32'h0, cyc, rd, er, we_cnt, wd_seen);
      check_eq("lh_data", 64'(rd), 64'hFFFF8877);
      run_op(OpLw, 32'h1004, 32'h0, cyc, rd, er, we_cnt, wd_seen);
      check_eq("lw_data", 64'(rd), 64'h88776655);

      run_op(OpLw, 32'h1002, 32'h0, cyc, rd, er, we_cnt, wd_seen);
`ifdef MAU_MISALIGN_TRAP_EN
      check_eq("mis_err", 64'(er), 64'd1);
      check_eq("mis_data", 64'(rd), 64'd0);
      check_eq("mis_cycle", 64'(cyc), 64'd1);
      check_eq("mis_we", 64'(we_cnt), 64'd0);
`else
      check_eq("mis_data", 64'(rd), 64'h44332211);
      check_eq("mis_err", 64'(er), 64'd0);
      check_eq("mis_cycle", 64'(cyc), 64'd2);
`endif

      err_inj = 1'b1;
      run_op(OpLw, 32'h1000, 32'h0, cyc, rd, er, we_cnt, wd_seen);
      check_eq("errld_err", 64'(er), 64'd1);
      check_eq("errld_cycle", 64'(cyc), 64'd2);
      run_op(OpSb, 32'h1000, 32'h55, cyc, rd, er, we_cnt, wd_seen);
      err_inj = 1'b0;
      check_eq("errst_err", 64'(er), 64'd1);
      check_eq("errst_cycle", 64'(cyc), 64'd2);
      check_eq("errst_we", 64'(we_cnt), 64'd0);
      check_eq("errst_mem", mem[0], model);

      run_op(OpSb, 32'h1001, 32'h000000AB, cyc, rd, er, we_cnt, wd_seen);
      model = 64'h887766554433AB11;
      check_eq("sb_we_cnt", 64'(we_cnt), 64'd1);
      check_eq("sb_wdata", wd_seen, model);
      check_eq("sb_cycle", 64'(cyc), 64'd3);
      check_eq("sb_rdata", 64'(rd), 64'd0);
      check_eq("sb_mem", mem[0], model);
      run_op(OpSw, 32'h1004, 32'hDEADBEEF, cyc, rd, er, we_cnt, wd_seen);
      model = 64'hDEADBEEF4433AB11;
      check_eq("sw_mem", mem[0], model);
      run_op(OpSh, 32'h1006, 32'h00001234, cyc, rd, er, we_cnt, wd_seen);
      model = 64'h1234BEEF4433AB11;
      check_eq("sh_mem", mem[0], model);
      run_op(OpLhu, 32'h1006, 32'h0, cyc, rd, er, we_cnt, wd_seen);
      check_eq("lhu2_data", 64'(rd), 64'h00001234);
      run_op(OpLh, 32'h1004, 32'h0, cyc, rd, er, we_cnt, wd_seen);
      check_eq("lh2_data", 64'(rd), 64'hFFFFBEEF);

      // Back-pressure: response must hold for five cycles.
      resp_ready = 1'b0;
      run_op(OpLw, 32'h1004, 32'h0, cyc, rd, er, we_cnt, wd_seen);
      check_eq("bp_data", 64'(rd), 64'h1234BEEF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("bp_valid", 64'(resp_valid), 64'd1);
         check_eq("bp_rdata", 64'(resp_rdata), 64'h1234BEEF);
         check_eq("bp_err", 64'(resp_err), 64'd0);
         check_eq("bp_req_ready", 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      #1 check_eq("bp_hs_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      check_eq("bp_after_req_ready", 64'(req_ready), 64'd1);
      check_eq("bp_after_valid", 64'(resp_valid), 64'd0);

      // Reset while in WR must suppress the write.
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OpSw;
      req_addr  = 32'h1000;
      req_wdata = 32'h0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rstwr_pre_we", 64'(mem_we), 64'd1);
      reset = 1'b0;
      #1 check_eq("rstwr_we_masked", 64'(mem_we), 64'd0);
      we_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (mem_we) we_cnt++;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (mem_we) we_cnt++;
      end
      check_eq("rstwr_we_cnt", 64'(we_cnt), 64'd0);
      check_eq("rstwr_mem", mem[0], model);
      check_eq("rstwr_req_ready", 64'(req_ready), 64'd1);
      check_eq("rstwr_resp_valid", 64'(resp_valid), 64'd0);

      run_op(OpLw, 32'h1000, 32'h0, cyc, rd, er, we_cnt, wd_seen);
      check_eq("post_rst_lw", 64'(rd), 64'h4433AB11);
      check_eq("post_rst_cycle", 64'(cyc), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
